// File: rtl/alu_op_decoder.sv
// alu_op_decoder
//   RV32I decode stage for the ALU: decodes one instruction word (LUI, AUIPC,
//   ADDI, ADD, SUB), gathers its operands and holds the result in one
//   registered ID/EX stage with a valid/ready handshake, stall and flush.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready is combinational
//   in_instr/in_pc  instruction word and its PC
//   rs1/rs2_addr    register-file read addresses (combinational from in_instr)
//   rs1/rs2_data    register-file read data for the same cycle
//   flush           drops the held entry and any incoming instruction
//   out_valid/ready downstream handshake toward the ALU
//   out_aluop       nop=0 lui=1 auipc=2 add=3 sub=4
//   out_a/out_b     operands
//   out_pc          PC of held instruction, RST_PC while empty
//   out_rd/rd_we    destination register and writeback enable
//   out_illegal     instruction not in the supported subset
module alu_op_decoder #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_aluop,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LUI   = 5'b00001;
  localparam logic [4:0] OP_AUIPC = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_i;

  logic [4:0]      dec_aluop;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_illegal;
  logic            dec_rd_we;

  logic            accept;
  logic [XLEN-1:0] pc_q;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd       = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // Immediates are sign-extended so a wider XLEN behaves like RV64.
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_i = XLEN'($signed(in_instr[31:20]));

  always_comb begin
    dec_aluop   = OP_NOP;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_LUI: begin
        dec_aluop   = OP_LUI;
        dec_b       = imm_u;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec_aluop   = OP_AUIPC;
        dec_a       = in_pc;
        dec_b       = imm_u;
        dec_illegal = 1'b0;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b000) begin
          dec_aluop   = OP_ADD;
          dec_a       = rs1_data;
          dec_b       = imm_i;
          dec_illegal = 1'b0;
        end
      end
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_aluop   = OP_ADD;
          dec_a       = rs1_data;
          dec_b       = rs2_data;
          dec_illegal = 1'b0;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_aluop   = OP_SUB;
          dec_a       = rs1_data;
          dec_b       = rs2_data;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign dec_rd_we = !dec_illegal && (rd != 5'd0);

  // During flush the stage advertises ready so upstream is never blocked,
  // but whatever it hands over is discarded.
  assign in_ready = !out_valid || out_ready || flush;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_aluop   <= OP_NOP;
      out_a       <= '0;
      out_b       <= '0;
      pc_q        <= RST_PC;
      out_rd      <= 5'd0;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_aluop   <= dec_aluop;
      out_a       <= dec_a;
      out_b       <= dec_b;
      pc_q        <= in_pc;
      out_rd      <= rd;
      out_rd_we   <= dec_rd_we;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc = out_valid ? pc_q : RST_PC;

endmodule
